// File: rtl/xfetch.sv
// -----------------------------------------------------------------------------
// xfetch - instruction fetch stage in front of the program ROM.
//
// Owns the program counter and drives the ROM read address every cycle. The
// ROM returns a registered word one cycle later. That word is captured into an
// output register and handed to decode together with the address it came from.
//
// Decode back-pressure (stall) is handled by replaying the word that was in
// flight when the output register filled up. A taken branch redirects the PC
// and squashes both the in-flight word and the output word.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst_n        asynchronous, active-low reset
//   stall        decode cannot accept the current instruction this cycle
//   branch_en    taken branch/jump; redirects fetch on this edge
//   branch_addr  branch target address
//   pc           ROM read address (the pc_q register)
//   rom_instr    ROM data for the address presented one cycle earlier
//   instr        registered instruction to decode
//   instr_pc     address of instr
//   instr_valid  instr holds a live instruction
// -----------------------------------------------------------------------------

`ifndef PROG_ROM_ADDR_W
`define PROG_ROM_ADDR_W 8
`endif

`ifndef INSTR_W
`define INSTR_W 16
`endif

module xfetch #(
    parameter int                ADDR_W    = `PROG_ROM_ADDR_W,
    parameter int                INSTR_W   = `INSTR_W,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] rom_instr,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    // Fetch pipeline: pc_q is on the ROM address bus, fpc_q/fvalid_q describe
    // the word currently on rom_instr.
    logic [ADDR_W-1:0]  pc_q,          pc_d;
    logic [ADDR_W-1:0]  fpc_q,         fpc_d;
    logic               fvalid_q,      fvalid_d;

    // Output register towards decode.
    logic [INSTR_W-1:0] instr_q,       instr_d;
    logic [ADDR_W-1:0]  instr_pc_q,    instr_pc_d;
    logic               instr_valid_q, instr_valid_d;

    // The output register can take a new word when it is empty or when its
    // current word is consumed on this edge.
    logic               accept;

    always_comb begin
        accept        = !instr_valid_q || !stall;

        pc_d          = pc_q;
        fpc_d         = fpc_q;
        fvalid_d      = fvalid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (branch_en) begin
            // Redirect wins over stall: both the in-flight word and the
            // word waiting in the output register belong to the old path.
            pc_d          = branch_addr;
            fvalid_d      = 1'b0;
            instr_valid_d = 1'b0;
        end else if (accept) begin
            if (fvalid_q) begin
                instr_d       = rom_instr;
                instr_pc_d    = fpc_q;
                instr_valid_d = 1'b1;
            end else begin
                instr_valid_d = 1'b0;
            end
            fpc_d    = pc_q;
            fvalid_d = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
        end else begin
            // Output register is full and held. The word on rom_instr has
            // nowhere to go, so drop it and re-issue its address; the ROM
            // then returns it again once decode frees up. With nothing in
            // flight the PC simply waits.
            if (fvalid_q) begin
                pc_d     = fpc_q;
                fvalid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= BOOT_ADDR;
            fpc_q         <= '0;
            fvalid_q      <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fpc_q         <= fpc_d;
            fvalid_q      <= fvalid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_xfetch.sv
module tb_xfetch;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam logic [AW-1:0] BOOT = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          branch_en;
    logic [AW-1:0] branch_addr;
    logic [AW-1:0] pc;
    logic [IW-1:0] rom_instr = '0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] exp_q[$];

    xfetch #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .BOOT_ADDR(BOOT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_addr(branch_addr),
        .pc         (pc),
        .rom_instr  (rom_instr),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return IW'(a) + 16'h0100;
    endfunction

    // Registered ROM: data for the address seen at an edge appears after it.
    always @(posedge clk) rom_instr <= mem_word(pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + AW'(1);
        end
    endtask

    // One clock. A word consumed on this edge is checked against the
    // scoreboard before the edge; outputs are then sampled 1ns after it.
    task automatic tick();
        logic [AW-1:0] e;
        if (rst_n === 1'b1 && instr_valid === 1'b1 && stall === 1'b0 && branch_en === 1'b0) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow: observed pc %0h expected no word", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", 32'(instr_pc), 32'(e));
                chk("sb_instr", 32'(instr), 32'(mem_word(e)));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [AW-1:0] ipc, input logic [AW-1:0] p);
        chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
        if (v) begin
            chk({tag, "_pc"}, 32'(instr_pc), 32'(ipc));
            chk({tag, "_instr"}, 32'(instr), 32'(mem_word(ipc)));
        end
        chk({tag, "_fetch"}, 32'(pc), 32'(p));
    endtask

    initial begin
        // Reset with X on control inputs.
        rst_n       = 1'b0;
        stall       = 1'bx;
        branch_en   = 1'bx;
        branch_addr = 'x;
        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'(BOOT));
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_ipc", 32'(instr_pc), 32'd0);

        rst_n       = 1'b1;
        stall       = 1'b0;
        branch_en   = 1'b0;
        branch_addr = '0;
        push_run(BOOT, 16);

        // Free run: first valid on 2nd edge, then one per cycle.
        tick();
        chk_out("boot1", 1'b0, 8'h00, 8'h01);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk_out("run", 1'b1, AW'(k - 2), AW'(k));
        end

        // Stall 3 cycles while 0x105 is held.
        stall = 1'b1;
        tick();
        chk_out("stall1", 1'b1, 8'h05, 8'h06);
        tick();
        chk_out("stall2", 1'b1, 8'h05, 8'h06);
        tick();
        chk_out("stall3", 1'b1, 8'h05, 8'h06);
        stall = 1'b0;
        tick();
        chk_out("bubble", 1'b0, 8'h00, 8'h07);
        tick();
        chk_out("replay6", 1'b1, 8'h06, 8'h08);
        tick();
        chk_out("after7", 1'b1, 8'h07, 8'h09);

        // Async reset in the middle of a stall.
        stall = 1'b1;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_instr", 32'(instr), 32'd0);
        chk("arst_ipc", 32'(instr_pc), 32'd0);
        chk("arst_pc", 32'(pc), 32'(BOOT));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        push_run(BOOT, 8);
        tick();
        chk_out("re1", 1'b0, 8'h00, 8'h01);
        tick();
        chk_out("re2", 1'b1, 8'h00, 8'h02);
        tick();
        tick();
        tick();
        chk_out("re5", 1'b1, 8'h03, 8'h05);

        // Branch while word 3 is valid and stalled.
        stall       = 1'b1;
        branch_en   = 1'b1;
        branch_addr = 8'h20;
        exp_q.delete();
        push_run(8'h20, 4);
        tick();
        chk_out("br_edge", 1'b0, 8'h00, 8'h20);
        stall     = 1'b0;
        branch_en = 1'b0;
        tick();
        chk_out("br_bub", 1'b0, 8'h00, 8'h21);
        tick();
        chk_out("br_t0", 1'b1, 8'h20, 8'h22);
        tick();
        chk_out("br_t1", 1'b1, 8'h21, 8'h23);

        // Back-to-back branches: 0x10 then 0x30.
        branch_en   = 1'b1;
        branch_addr = 8'h10;
        exp_q.delete();
        tick();
        chk_out("bb1", 1'b0, 8'h00, 8'h10);
        branch_addr = 8'h30;
        push_run(8'h30, 4);
        tick();
        chk_out("bb2", 1'b0, 8'h00, 8'h30);
        branch_en = 1'b0;
        tick();
        chk_out("bb_bub", 1'b0, 8'h00, 8'h31);
        tick();
        chk_out("bb_t0", 1'b1, 8'h30, 8'h32);
        tick();
        chk_out("bb_t1", 1'b1, 8'h31, 8'h33);

        // Wrap at the top of the address space; stall during the bubble
        // must not hold anything back.
        branch_en   = 1'b1;
        branch_addr = 8'hFE;
        exp_q.delete();
        push_run(8'hFE, 6);
        tick();
        chk_out("wr_br", 1'b0, 8'h00, 8'hFE);
        branch_en = 1'b0;
        stall     = 1'b1;
        tick();
        chk_out("wr_bub", 1'b0, 8'h00, 8'hFF);
        stall = 1'b0;
        tick();
        chk_out("wr_fe", 1'b1, 8'hFE, 8'h00);
        tick();
        chk_out("wr_ff", 1'b1, 8'hFF, 8'h01);
        tick();
        chk_out("wr_00", 1'b1, 8'h00, 8'h02);
        tick();
        chk_out("wr_01", 1'b1, 8'h01, 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
